// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a 2-flop input synchronizer, show-ahead receive FIFO,
// and sticky framing-error / overrun flags.
module uart_rx_fifo #(
    parameter int unsigned DIVISOR = 87,
    parameter int unsigned DEPTH   = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       RXD,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       clr_err,
    output logic       frame_err,
    output logic       overrun
);
    localparam int unsigned CntW = $clog2(DIVISOR + 1);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [CntW-1:0] BitCnt   = CntW'(DIVISOR);
    localparam logic [CntW-1:0] HalfCnt  = CntW'(DIVISOR / 2);
    localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            rx_meta_q, rx_s_q;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            frame_err_q, overrun_q;

    logic cnt_done, stop_hit, pop, full, push, set_ovr, set_ferr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RXD;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        cnt_done = (cnt_q == CntW'(1));
        stop_hit = (state_q == StStop) && cnt_done;
        pop      = rd_en && rd_valid;
        full     = (count_q == DepthCnt);
        // A pop in the stop-sample cycle frees the slot the new byte needs.
        push     = stop_hit && rx_s_q && (!full || pop);
        set_ovr  = stop_hit && rx_s_q && full && !pop;
        set_ferr = stop_hit && !rx_s_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        cnt_q   <= HalfCnt;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_done) begin
                        if (rx_s_q) begin
                            state_q <= StIdle;
                        end else begin
                            cnt_q     <= BitCnt;
                            bit_idx_q <= '0;
                            state_q   <= StData;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_done) begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        cnt_q   <= BitCnt;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_done) begin
                        state_q <= rx_s_q ? StIdle : StWaitHigh;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StWaitHigh: begin
                    // Sit out a break until the line returns high.
                    if (rx_s_q) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
        end
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= set_ferr | (frame_err_q & ~clr_err);
            overrun_q   <= set_ovr | (overrun_q & ~clr_err);
        end
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign rd_valid  = (count_q != '0);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: drives 8N1 frames mid-cycle and checks against a queue-level
// model of the receive FIFO and its sticky flags.
module tb_uart_rx_fifo;
    localparam int unsigned DIV  = 8;
    localparam int unsigned DEP  = 4;
    localparam int unsigned HALF = DIV / 2;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rxd;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       clr_err;
    logic       frame_err;
    logic       overrun;

    int tests_run = 0;
    int fails = 0;

    logic [7:0] m_q[$];
    logic       m_ovr;
    logic       m_ferr;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DIVISOR(DIV), .DEPTH(DEP)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .RXD      (rxd),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .clr_err  (clr_err),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    function automatic void model_frame(input logic [7:0] b, input logic stop,
                                        input bit popped, input bit clr);
        if (popped && m_q.size() != 0) void'(m_q.pop_front());
        if (clr) begin
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end
        if (!stop) m_ferr = 1'b1;
        else if (m_q.size() < DEP) m_q.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    // Called just after a negedge. RXD changes mid-cycle, so the FSM detects the start bit
    // at the 3rd following posedge; the stop sample lands HALF + 9*DIV posedges after that.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_at_stop,
                              input bit clr_at_stop, output logic pre_v, output logic post_v,
                              output logic [7:0] post_d);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop;
        repeat (HALF + 2) @(negedge clk);
        pre_v   = rd_valid;
        rd_en   = pop_at_stop;
        clr_err = clr_at_stop;
        @(negedge clk);
        rd_en   = 1'b0;
        clr_err = 1'b0;
        post_v  = rd_valid;
        post_d  = rd_data;
        model_frame(b, stop, pop_at_stop, clr_at_stop);
        repeat (DIV - HALF - 3) @(negedge clk);
    endtask

    task automatic do_pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (m_q.size() != 0) void'(m_q.pop_front());
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (rd_valid !== 1'b0) begin
            fails++; $display("FAIL reset_rd_valid got %b want 0", rd_valid);
        end
        tests_run++;
        if (rd_data !== 8'h00) begin
            fails++; $display("FAIL reset_rd_data got %h want 00", rd_data);
        end
        tests_run++;
        if ({frame_err, overrun} !== 2'b00) begin
            fails++; $display("FAIL reset_flags got %b%b want 00", frame_err, overrun);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_byte();
        logic pv, qv;
        logic [7:0] qd;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, pv, qv, qd);
        tests_run++;
        if (pv !== 1'b0) begin
            fails++; $display("FAIL single_valid_early got %b want 0", pv);
        end
        tests_run++;
        if (qv !== 1'b1) begin
            fails++; $display("FAIL single_valid_after_stop got %b want 1", qv);
        end
        tests_run++;
        if (qd !== 8'hA5) begin
            fails++; $display("FAIL single_data got %h want a5", qd);
        end
        do_pop();
        tests_run++;
        if (rd_valid !== 1'b0) begin
            fails++; $display("FAIL single_pop_valid got %b want 0", rd_valid);
        end
        tests_run++;
        if ({frame_err, overrun} !== 2'b00) begin
            fails++; $display("FAIL single_flags got %b%b want 00", frame_err, overrun);
        end
    endtask

    task automatic test_fill_overrun();
        logic pv, qv;
        logic [7:0] qd;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0, pv, qv, qd);
            if (i == 4) begin
                tests_run++;
                if (overrun !== 1'b0) begin
                    fails++; $display("FAIL fill_no_overrun_at_4 got %b want 0", overrun);
                end
            end
        end
        tests_run++;
        if (overrun !== 1'b1) begin
            fails++; $display("FAIL fill_overrun got %b want 1", overrun);
        end
        for (int i = 1; i <= 4; i++) begin
            tests_run++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                fails++;
                $display("FAIL fill_pop_%0d got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data,
                         8'(i));
            end
            do_pop();
        end
        tests_run++;
        if (rd_valid !== 1'b0) begin
            fails++; $display("FAIL fill_drained got %b want 0", rd_valid);
        end
        pulse_clr();
        tests_run++;
        if (overrun !== 1'b0) begin
            fails++; $display("FAIL fill_clr_overrun got %b want 0", overrun);
        end
    endtask

    task automatic test_glitch();
        logic pv, qv;
        logic [7:0] qd;
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        tests_run++;
        if ({rd_valid, frame_err, overrun} !== 3'b000) begin
            fails++;
            $display("FAIL glitch_quiet got v=%b fe=%b ov=%b want 000", rd_valid, frame_err,
                     overrun);
        end
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, pv, qv, qd);
        tests_run++;
        if (qv !== 1'b1 || qd !== 8'h3C) begin
            fails++; $display("FAIL glitch_next_byte got v=%b d=%h want v=1 d=3c", qv, qd);
        end
        do_pop();
    endtask

    task automatic test_framing();
        logic pv, qv, any_v;
        logic [7:0] qd;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, pv, qv, qd);
        any_v = qv;
        repeat (20 * DIV) begin
            @(negedge clk);
            any_v = any_v | rd_valid;
        end
        tests_run++;
        if (any_v !== 1'b0) begin
            fails++; $display("FAIL frame_no_push got %b want 0", any_v);
        end
        tests_run++;
        if (frame_err !== 1'b1) begin
            fails++; $display("FAIL frame_err_set got %b want 1", frame_err);
        end
        rxd = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, pv, qv, qd);
        tests_run++;
        if (qv !== 1'b1 || qd !== 8'hC3) begin
            fails++; $display("FAIL frame_next_byte got v=%b d=%h want v=1 d=c3", qv, qd);
        end
        tests_run++;
        if (frame_err !== 1'b1) begin
            fails++; $display("FAIL frame_err_sticky got %b want 1", frame_err);
        end
        do_pop();
        pulse_clr();
        tests_run++;
        if (frame_err !== 1'b0) begin
            fails++; $display("FAIL frame_err_clr got %b want 0", frame_err);
        end
    endtask

    task automatic test_full_pop();
        logic pv, qv;
        logic [7:0] qd;
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, pv, qv, qd);
        send_frame(8'($urandom), 1'b1, 1'b1, 1'b0, pv, qv, qd);
        tests_run++;
        if (overrun !== 1'b0) begin
            fails++; $display("FAIL fullpop_no_overrun got %b want 0", overrun);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (rd_valid !== 1'b1 || rd_data !== m_q[0]) begin
                fails++;
                $display("FAIL fullpop_order_%0d got v=%b d=%h want v=1 d=%h", i, rd_valid,
                         rd_data, m_q[0]);
            end
            do_pop();
        end
        tests_run++;
        if (rd_valid !== 1'b0) begin
            fails++; $display("FAIL fullpop_count got %b want 0 after 4 pops", rd_valid);
        end
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, pv, qv, qd);
        send_frame(8'($urandom), 1'b1, 1'b0, 1'b1, pv, qv, qd);
        tests_run++;
        if (overrun !== 1'b1) begin
            fails++; $display("FAIL fullpop_set_beats_clr got %b want 1", overrun);
        end
        while (m_q.size() != 0) begin
            tests_run++;
            if (rd_data !== m_q[0]) begin
                fails++; $display("FAIL fullpop_drain got %h want %h", rd_data, m_q[0]);
            end
            do_pop();
        end
        pulse_clr();
    endtask

    task automatic test_reset_midframe();
        logic pv, qv;
        logic [7:0] qd, b;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, pv, qv, qd);
        b = 8'($urandom);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            rxd = b[k];
            repeat (DIV) @(negedge clk);
        end
        rxd = b[3];
        repeat (HALF) @(negedge clk);
        resetn = 1'b0;
        #1;
        m_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        tests_run++;
        if ({rd_valid, rd_data, frame_err, overrun} !== 11'h0) begin
            fails++;
            $display("FAIL midreset_outputs got v=%b d=%h fe=%b ov=%b want all 0", rd_valid,
                     rd_data, frame_err, overrun);
        end
        repeat (2) @(negedge clk);
        rxd    = 1'b1;
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h9E, 1'b1, 1'b0, 1'b0, pv, qv, qd);
        tests_run++;
        if (pv !== 1'b0 || qv !== 1'b1 || qd !== 8'h9E) begin
            fails++;
            $display("FAIL midreset_next_byte got pre=%b v=%b d=%h want pre=0 v=1 d=9e", pv,
                     qv, qd);
        end
        do_pop();
    endtask

    task automatic test_random();
        logic pv, qv, stop;
        logic [7:0] qd, b;
        bit pop_s;
        for (int it = 0; it < 16; it++) begin
            b     = 8'($urandom);
            stop  = ($urandom_range(0, 7) != 0);
            pop_s = bit'($urandom_range(0, 1));
            send_frame(b, stop, pop_s, 1'b0, pv, qv, qd);
            tests_run++;
            if (qv !== (m_q.size() != 0)) begin
                fails++; $display("FAIL rand_valid_%0d got %b want %b", it, qv, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                tests_run++;
                if (qd !== m_q[0]) begin
                    fails++; $display("FAIL rand_head_%0d got %h want %h", it, qd, m_q[0]);
                end
            end
            tests_run++;
            if (overrun !== m_ovr || frame_err !== m_ferr) begin
                fails++;
                $display("FAIL rand_flags_%0d got ov=%b fe=%b want ov=%b fe=%b", it, overrun,
                         frame_err, m_ovr, m_ferr);
            end
            if (!stop) begin
                rxd = 1'b1;
                repeat (4) @(negedge clk);
            end
            repeat ($urandom_range(0, 2)) begin
                if (m_q.size() != 0) begin
                    tests_run++;
                    if (rd_data !== m_q[0]) begin
                        fails++; $display("FAIL rand_pop_%0d got %h want %h", it, rd_data, m_q[0]);
                    end
                end
                do_pop();
            end
            if ($urandom_range(0, 3) == 0) pulse_clr();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn  = 1'b0;
        rxd     = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_fill_overrun();
        test_glitch();
        test_framing();
        test_full_pop();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
